// File: rtl/imem_rport_pkg.sv
// Shared constants for the instruction-fetch read port responder.
// Holds the m_rlen size encodings, the FSM state encodings and a
// helper that maps a size code to its byte count.
package imem_rport_pkg;

  // m_rlen size codes (2'd2 is reserved and always reported as an error)
  localparam logic [1:0] RLEN_B   = 2'd0;
  localparam logic [1:0] RLEN_H   = 2'd1;
  localparam logic [1:0] RLEN_RSV = 2'd2;
  localparam logic [1:0] RLEN_W   = 2'd3;

  typedef enum logic [1:0] {
    IMR_IDLE = 2'd0,
    IMR_WAIT = 2'd1,
    IMR_ACK  = 2'd2
  } imr_state_t;

  // Number of bytes covered by a size code; the reserved code maps to 1 so
  // that the range arithmetic stays well defined (it errors out anyway).
  function automatic logic [2:0] rlen_bytes(input logic [1:0] rlen);
    case (rlen)
      RLEN_H:  rlen_bytes = 3'd2;
      RLEN_W:  rlen_bytes = 3'd4;
      default: rlen_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/imem_bytearray.sv
// Byte-addressed storage for the fetch read port.
// One synchronous byte write port (loader) and four combinational byte
// read ports at raddr..raddr+3. Read ports past the end of storage return 0;
// the caller flags those accesses as errors, so the value is never used.
module imem_bytearray
  import imem_rport_pkg::*;
#(
  parameter int MADDR_L   = 32,
  parameter int MEM_BYTES = 8192
) (
  input  logic               clk,
  input  logic               we,
  input  logic [MADDR_L-1:0] waddr,
  input  logic [7:0]         wdata,
  input  logic [MADDR_L-1:0] raddr,
  output logic [31:0]        rdata
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  logic [7:0] mem [MEM_BYTES];

  // Loader byte write; out-of-range addresses are dropped rather than wrapped
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < (MADDR_L+1)'(MEM_BYTES))) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      logic [MADDR_L:0] a_k;
      // Extra MSB keeps raddr+gi from wrapping back into valid storage
      assign a_k = {1'b0, raddr} + (MADDR_L+1)'(gi);
      assign rdata[8*gi +: 8] = (a_k < (MADDR_L+1)'(MEM_BYTES)) ? mem[a_k[AW-1:0]] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/imem_rport.sv
// Responding end of the instruction-fetch read handshake.
// Four-phase m_re/m_rack handshake with WAIT_CYC wait cycles before the
// acknowledge; dataout/m_err are captured once and held until the next capture.
// Optional feature macro: IMEM_MISALIGN_EN -- when defined, halfword and word
// reads may start at any byte address; otherwise misaligned reads complete
// with m_err=1 and dataout=0.
module imem_rport
  import imem_rport_pkg::*;
#(
  parameter int MADDR_L   = 32,
  parameter int DATA_L    = 32,
  parameter int MEM_BYTES = 8192,
  parameter int WAIT_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_re,
  input  logic [MADDR_L-1:0] addr,
  input  logic [1:0]         m_rlen,
  output logic               m_rack,
  output logic [DATA_L-1:0]  dataout,
  output logic               m_err,
  input  logic               ld_we,
  input  logic [MADDR_L-1:0] ld_addr,
  input  logic [7:0]         ld_data
);

  localparam int CW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

  imr_state_t         state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [MADDR_L-1:0] addr_reg;
  logic [1:0]         rlen_reg;
  logic [DATA_L-1:0]  dout_reg;
  logic               err_reg;
  logic               capture;

  logic [MADDR_L-1:0] rd_addr;
  logic [1:0]         rd_len;
  logic [31:0]        rd_bytes;
  logic [2:0]         nbytes;
  logic [MADDR_L:0]   last_addr;
  logic               range_err;
  logic               align_err;
  logic               rd_err;
  logic [31:0]        word32;
  logic [DATA_L-1:0]  rd_word;

  // In IDLE the request is captured straight from the ports (only reachable
  // with WAIT_CYC=0); afterwards the latched copy is used so that address and
  // size changes during the request have no effect.
  assign rd_addr = (state_reg == IMR_IDLE) ? addr : addr_reg;
  assign rd_len  = (state_reg == IMR_IDLE) ? m_rlen : rlen_reg;

  imem_bytearray #(
    .MADDR_L   (MADDR_L),
    .MEM_BYTES (MEM_BYTES)
  ) u_bytes (
    .clk   (clk),
    .we    (ld_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (rd_addr),
    .rdata (rd_bytes)
  );

  // State register and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IMR_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: abort in WAIT wins over capture, capture when counter is 0
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IMR_IDLE: begin
        if (m_re) begin
          cnt_next = CW'(WAIT_CYC);
          if (WAIT_CYC == 0) begin
            capture    = 1'b1;
            state_next = IMR_ACK;
          end else begin
            state_next = IMR_WAIT;
          end
        end
      end
      IMR_WAIT: begin
        if (!m_re) begin
          state_next = IMR_IDLE;
        end else if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = IMR_ACK;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      IMR_ACK: begin
        if (!m_re) begin
          state_next = IMR_IDLE;
        end
      end
      default: state_next = IMR_IDLE;
    endcase
  end

  // Error checks and little-endian, zero-extended data assembly
  always_comb begin
    nbytes    = rlen_bytes(rd_len);
    last_addr = {1'b0, rd_addr} + (MADDR_L+1)'(nbytes) - (MADDR_L+1)'(1);
    range_err = (last_addr >= (MADDR_L+1)'(MEM_BYTES));
`ifdef IMEM_MISALIGN_EN
    align_err = 1'b0;
`else
    align_err = ((rd_len == RLEN_H) && rd_addr[0]) ||
                ((rd_len == RLEN_W) && (rd_addr[1:0] != 2'b00));
`endif
    rd_err = (rd_len == RLEN_RSV) || range_err || align_err;
    word32 = '0;
    if (!rd_err) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) begin
          word32[8*k +: 8] = rd_bytes[8*k +: 8];
        end
      end
    end
    rd_word = DATA_L'(word32);
  end

  // Request latch and capture register; outputs hold between captures
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg <= '0;
      rlen_reg <= RLEN_B;
      dout_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if ((state_reg == IMR_IDLE) && m_re) begin
        addr_reg <= addr;
        rlen_reg <= m_rlen;
      end
      if (capture) begin
        dout_reg <= rd_word;
        err_reg  <= rd_err;
      end
    end
  end

  assign m_rack  = (state_reg == IMR_ACK);
  assign dataout = dout_reg;
  assign m_err   = err_reg;

endmodule

// File: tb/tb_imem_rport.sv
// Directed bench for imem_rport (WAIT_CYC=2, MEM_BYTES=8192).
// Expectations for misaligned reads follow IMEM_MISALIGN_EN.
module tb_imem_rport;

  localparam int MEM = 8192;
  localparam int WC  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_re;
  logic [31:0] addr;
  logic [1:0]  m_rlen;
  logic        m_rack;
  logic [31:0] dataout;
  logic        m_err;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [7:0]  ld_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_rport #(
    .MADDR_L   (32),
    .DATA_L    (32),
    .MEM_BYTES (MEM),
    .WAIT_CYC  (WC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_re    (m_re),
    .addr    (addr),
    .m_rlen  (m_rlen),
    .m_rack  (m_rack),
    .dataout (dataout),
    .m_err   (m_err),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Called and returns at a negedge
  task automatic ld(input logic [31:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  // One read transaction; ld_at = edge index (E0=0) carrying a loader write
  task automatic rd(input string tag, input logic [31:0] a, input logic [1:0] len,
                    input logic [31:0] exp_d, input logic exp_e,
                    input int ld_at, input bit hold);
    int k;
    addr   = a;
    m_rlen = len;
    m_re   = 1'b1;
    @(posedge clk);               // E0
    @(negedge clk);
    addr   = ~a;                  // must be ignored by the responder
    m_rlen = 2'd2;
    chk({tag, ".pre"}, {31'b0, m_rack}, 32'd0);
    k = 0;
    while (!m_rack && k < 20) begin
      ld_we = (k == ld_at - 1);
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    ld_we = 1'b0;
    chk({tag, ".lat"}, 32'(k), 32'd3);
    chk({tag, ".data"}, dataout, exp_d);
    chk({tag, ".err"}, {31'b0, m_err}, {31'b0, exp_e});
    $display("read %s addr=%08h len=%0d data=%08h err=%0b lat=%0d", tag, a, len, dataout, m_err, k);
    if (!hold) begin
      m_re = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".drop"}, {31'b0, m_rack}, 32'd0);
      chk({tag, ".hold"}, dataout, exp_d);
      chk({tag, ".eh"}, {31'b0, m_err}, {31'b0, exp_e});
    end
  endtask

  initial begin
    int seen;
    rst = 1'b0; m_re = 1'b0; addr = '0; m_rlen = 2'd0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rack", {31'b0, m_rack}, 32'd0);
    chk("rst.data", dataout, 32'd0);
    chk("rst.err", {31'b0, m_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    ld(0, 8'h13); ld(1, 8'h05); ld(2, 8'h00); ld(3, 8'h00);
    ld(4, 8'h00); ld(5, 8'h00); ld(6, 8'h00); ld(7, 8'h00);
    ld(MEM-4, 8'h11); ld(MEM-3, 8'h22); ld(MEM-2, 8'h33); ld(MEM-1, 8'h44);
    ld(MEM, 8'hAA);               // out of range: must not land on byte 0

    rd("w0", 0, 2'd3, 32'h0000_0513, 1'b0, -1, 1'b0);
    rd("b2", 2, 2'd0, 32'h0000_0000, 1'b0, -1, 1'b0);
    rd("h0", 0, 2'd1, 32'h0000_0513, 1'b0, -1, 1'b0);
    rd("b0", 0, 2'd0, 32'h0000_0013, 1'b0, -1, 1'b0);
`ifdef IMEM_MISALIGN_EN
    rd("w1", 1, 2'd3, 32'h0000_0005, 1'b0, -1, 1'b0);
    rd("h1", 1, 2'd1, 32'h0000_0005, 1'b0, -1, 1'b0);
`else
    rd("w1", 1, 2'd3, 32'h0000_0000, 1'b1, -1, 1'b0);
    rd("h1", 1, 2'd1, 32'h0000_0000, 1'b1, -1, 1'b0);
`endif
    rd("wtop",  MEM-4, 2'd3, 32'h4433_2211, 1'b0, -1, 1'b0);
    rd("htop",  MEM-2, 2'd1, 32'h0000_4433, 1'b0, -1, 1'b0);
    rd("btop",  MEM-1, 2'd0, 32'h0000_0044, 1'b0, -1, 1'b0);
    rd("wover", MEM-2, 2'd3, 32'h0000_0000, 1'b1, -1, 1'b0);
    rd("hover", MEM-1, 2'd1, 32'h0000_0000, 1'b1, -1, 1'b0);
    rd("bover", MEM,   2'd0, 32'h0000_0000, 1'b1, -1, 1'b0);
    rd("rsv",   0,     2'd2, 32'h0000_0000, 1'b1, -1, 1'b0);

    // Abort during WAIT: no acknowledge may appear
    addr = 0; m_rlen = 2'd3; m_re = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    m_re = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (m_rack) seen++;
    end
    chk("abort.rack", 32'(seen), 32'd0);
    $display("read abort addr=00000000 rack_cycles=%0d", seen);
    rd("after_abort", 0, 2'd3, 32'h0000_0513, 1'b0, -1, 1'b0);

    // Loader write to byte 0 on the capture edge: capture sees the old byte
    ld_addr = 0; ld_data = 8'hFF;
    rd("coll", 0, 2'd3, 32'h0000_0513, 1'b0, 3, 1'b0);
    rd("newb", 0, 2'd3, 32'h0000_05FF, 1'b0, -1, 1'b0);

    // Reset while in ACK drops m_rack without waiting for a clock edge
    rd("hold", 0, 2'd3, 32'h0000_05FF, 1'b0, -1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rstack.rack", {31'b0, m_rack}, 32'd0);
    chk("rstack.data", dataout, 32'd0);
    chk("rstack.err", {31'b0, m_err}, 32'd0);
    $display("reset in ack: rack=%0b data=%08h", m_rack, dataout);
    m_re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd("post_rst", 0, 2'd0, 32'h0000_00FF, 1'b0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
